shift_operand_decode: RTL and testbench
=======================================

Name: shift_operand_decode

Overview:
- Pipeline stage directly upstream of the barrel shifter (inputs a[31:0], shamt5[4:0], sh[1:0]; sh encoding 00 LSL, 01 LSR, 10 ASR, 11 ROR).
- Decodes the Operand2 field of an ARM data-processing instruction into registered shifter controls.
- Handles immediate rotate, immediate shift and register-specified shift; a register shift takes one extra cycle on the shared Rs read port.
- Valid/ready handshake on both sides; single output register.

Parameters:
- DW, 32, operand width (a, rm_data, rs_data).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  instr/rm_data valid.
- in_ready  output  1  stage accepts the instruction this cycle.
- instr  input  32  instruction word.
- rm_data  input  DW  value of Rm (instr[3:0]), valid with in_valid.
- rs_addr  output  4  Rs register index for the shared read port.
- rs_data  input  DW  register-file read of rs_addr, combinational, same cycle.
- out_valid  output  1  shifter controls valid.
- out_ready  input  1  shifter stage consumes the output.
- a  output  DW  value to shift.
- shamt5  output  5  shift amount.
- sh  output  2  shift type.
- amt32  output  1  effective amount is ≥32; downstream forces 0 (LSL/LSR) or sign fill (ASR).
- rrx  output  1  rotate right extended (ROR #0 immediate form).

Behaviour:
- Reset values:
  - out_valid, a, shamt5, sh, amt32, rrx = 0.
  - rs_addr = 0.
  - State = IDLE.
- Handshake: transfer on in_valid&&in_ready, or out_valid&&out_ready. free = !out_valid || out_ready.
- FSM:
  - IDLE:
    - in_ready = free.
    - On accept with instr[25]==0 && instr[4]==1 (register shift):
      - capture instr and rm_data; rs_addr <= instr[11:8]; go to RS.
      - out_valid <= 0 if the current output drained this edge.
    - Any other accept: load outputs, out_valid <= 1, stay IDLE.
  - RS:
    - in_ready = 0; rs_addr held.
    - If free: load outputs from the captured instr/rm_data and the current rs_data; out_valid <= 1; go to IDLE.
    - Else stay in RS; rs_data is re-read each cycle.
- If out_valid && !out_ready in IDLE with no new load: hold all outputs stable.
- Latency, accept to out_valid:
  - 1 cycle for immediate and immediate-shift forms; throughput 1 per cycle.
  - 2 cycles for register shift; throughput 1 per 2 cycles.
- Decode, immediate (instr[25]==1):
  - a = zero-extended instr[7:0]; shamt5 = {instr[11:8],1'b0}; sh = 11; amt32 = rrx = 0.
- Decode, immediate shift (instr[25]==0, instr[4]==0):
  - a = rm_data; sh = instr[6:5]; shamt5 = instr[11:7].
  - Special case, imm5==0 with sh in {01,10}: shamt5 = 0, amt32 = 1 (encodes #32).
  - Special case, imm5==0 with sh==11: rrx = 1, shamt5 = 0.
  - LSL #0 is a plain pass-through; all flags 0.
- Decode, register shift:
  - a = rm_data; sh = instr[6:5]; amt = rs_data[7:0].
  - sh==11: shamt5 = amt[4:0], amt32 = 0.
  - Otherwise, amt ≥ 32: shamt5 = 0, amt32 = 1.
  - Otherwise, amt < 32: shamt5 = amt[4:0], amt32 = 0.
  - rrx = 0 always; amt==0 gives pass-through.
- Reset asserted in any state, including RS with a captured instruction:
  - next cycle IDLE; captured instruction discarded; outputs at reset values.
- Reset has priority over simultaneous in/out transfers.

Test Plan:
- Immediate: instr=0xE3A000FF accepted at cycle 0 -> cycle 1: out_valid=1, a=0x000000FF, shamt5=0, sh=11, amt32=0, rrx=0.
- Immediate shift: instr=0xE1A00102, rm_data=5 -> next cycle: a=5, shamt5=2, sh=00. Back-to-back with instr=0xE1A00142, rm_data=4 (ASR #2) -> following cycle: a=4, shamt5=2, sh=10; in_ready stays 1 throughout.
- LSR #0 / ROR #0: instr=0xE1A00022 -> sh=01, shamt5=0, amt32=1. instr=0xE1A00062 -> sh=11, rrx=1, amt32=0.
- Register shift: instr=0xE1A00352, rm_data=0x80000000 -> cycle 1: rs_addr=3, in_ready=0. With rs_data=0x28: cycle 2 out_valid=1, a=0x80000000, sh=10, shamt5=0, amt32=1. Same with rs_data=0x21 and instr=0xE1A00372 (ROR): shamt5=1, amt32=0.
- Backpressure: out_ready=0 for 3 cycles after one valid output -> a/shamt5/sh unchanged, in_ready=0. A register-shift instruction waits in RS. out_ready=1 drains the held output; the RS result appears one cycle later.
- Reset mid-operation: assert reset during RS -> next cycle out_valid=0, rs_addr=0, in_ready=1 after deassertion; the discarded instruction never appears at the output.

Source files
------------

// File: rtl/shift_operand_decode_if.sv
// Handshake and data bundle between the Operand2 decoder, its upstream
// issue logic, the shared Rs register-file read port and the barrel shifter.
interface shift_operand_decode_if #(
  parameter int DW = 32
);
  // upstream instruction side
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   instr;
  logic [DW-1:0] rm_data;
  // shared Rs read port
  logic [3:0]    rs_addr;
  logic [DW-1:0] rs_data;
  // downstream shifter side
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] a;
  logic [4:0]    shamt5;
  logic [1:0]    sh;
  logic          amt32;
  logic          rrx;

  // decoder view
  modport slave (
    input  in_valid, instr, rm_data, rs_data, out_ready,
    output in_ready, rs_addr, out_valid, a, shamt5, sh, amt32, rrx
  );

  // environment view (issue logic, register file, shifter)
  modport master (
    output in_valid, instr, rm_data, rs_data, out_ready,
    input  in_ready, rs_addr, out_valid, a, shamt5, sh, amt32, rrx
  );
endinterface

// File: rtl/shift_operand_decode.sv
// Operand2 decoder: turns the shifter-operand field of an ARM data-processing
// instruction into registered barrel-shifter controls. Immediate and
// immediate-shift forms complete in one cycle; register-specified shifts
// spend one extra cycle reading Rs on the shared register-file port.
module shift_operand_decode #(
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_operand_decode_if.slave bus
);

  typedef enum logic {IDLE, RS} state_t;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [4:0]    shamt5;
    logic [1:0]    sh;
    logic          amt32;
    logic          rrx;
  } ctl_t;

  state_t        state;
  ctl_t          ctl;
  logic          out_valid_q;
  logic [3:0]    rs_addr_q;
  logic [1:0]    cap_sh;
  logic [DW-1:0] cap_rm;

  logic          free;
  logic          accept;
  logic          is_reg_shift;

  // Immediate rotate (imm=1) or immediate-shift decode of Operand2.
  function automatic ctl_t decode_direct(input logic imm, input logic [11:0] op2,
                                         input logic [DW-1:0] rm);
    ctl_t c;
    c = '0;
    if (imm) begin
      c.a      = DW'(op2[7:0]);
      c.shamt5 = {op2[11:8], 1'b0};
      c.sh     = 2'b11;
    end else begin
      c.a  = rm;
      c.sh = op2[6:5];
      c.shamt5 = op2[11:7];
      // A zero imm5 re-encodes LSR/ASR #32 and ROR #0 as RRX.
      if (op2[11:7] == 5'd0) begin
        if (op2[6:5] == 2'b01 || op2[6:5] == 2'b10) c.amt32 = 1'b1;
        else if (op2[6:5] == 2'b11)                 c.rrx   = 1'b1;
      end
    end
    return c;
  endfunction

  // Register-specified shift: only the bottom byte of Rs counts.
  function automatic ctl_t decode_reg(input logic [1:0] sh, input logic [DW-1:0] rm,
                                      input logic [7:0] amt);
    ctl_t c;
    c    = '0;
    c.a  = rm;
    c.sh = sh;
    if (sh == 2'b11)      c.shamt5 = amt[4:0];  // rotate is modulo 32
    else if (amt >= 8'd32) c.amt32 = 1'b1;
    else                  c.shamt5 = amt[4:0];
    return c;
  endfunction

  assign free         = !out_valid_q || bus.out_ready;
  assign bus.in_ready = (state == IDLE) && free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_reg_shift = !bus.instr[25] && bus.instr[4];

  assign bus.rs_addr   = rs_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.a         = ctl.a;
  assign bus.shamt5    = ctl.shamt5;
  assign bus.sh        = ctl.sh;
  assign bus.amt32     = ctl.amt32;
  assign bus.rrx       = ctl.rrx;

  // Condition, opcode and register-number bits play no part in this decode.
  logic unused_bits;
  assign unused_bits = ^{bus.instr[31:26], bus.instr[24:12], bus.rs_data[DW-1:8]};

  // Decode FSM with the single output register; reset wins over any transfer.
  always_ff @(posedge clk) begin
    // NOTE: every state element here uses <= so all of them see the
    // pre-edge values of each other, exactly like real flops.
    if (reset) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      ctl         <= '0;
      rs_addr_q   <= '0;
      cap_sh      <= '0;
      cap_rm      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_reg_shift) begin
              cap_sh      <= bus.instr[6:5];
              cap_rm      <= bus.rm_data;
              rs_addr_q   <= bus.instr[11:8];
              out_valid_q <= 1'b0;  // accept implies any old output drained
              state       <= RS;
            end else begin
              ctl         <= decode_direct(bus.instr[25], bus.instr[11:0], bus.rm_data);
              out_valid_q <= 1'b1;
            end
          end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        RS: begin
          if (free) begin
            ctl         <= decode_reg(cap_sh, cap_rm, bus.rs_data[7:0]);
            out_valid_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_operand_decode.sv
// Directed testbench for shift_operand_decode with hand-computed vectors.
module tb_shift_operand_decode;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_operand_decode_if #(.DW(DW)) bus ();

  // Register file behind the shared Rs port: combinational read.
  logic [DW-1:0] rf [16];
  assign bus.rs_data = rf[bus.rs_addr];

  shift_operand_decode #(.DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Observed output bundle {out_valid, a, shamt5, sh, amt32, rrx}.
  function automatic logic [41:0] obs();
    return {bus.out_valid, bus.a, bus.shamt5, bus.sh, bus.amt32, bus.rrx};
  endfunction

  function automatic logic [41:0] expv(input logic v, input logic [31:0] a,
                                       input logic [4:0] s, input logic [1:0] t,
                                       input logic m, input logic r);
    return {v, a, s, t, m, r};
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rm);
    bus.in_valid = v;
    bus.instr    = ins;
    bus.rm_data  = rm;
  endtask

  task automatic test_reset();
    logic [41:0] e;
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    repeat (2) step();
    e = '0;
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want %h", obs(), e);
    end
    vectors++;
    if (bus.rs_addr !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_rs_addr: got %h want 0", bus.rs_addr);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_immediate();
    logic [41:0] e;
    drive(1'b1, 32'hE3A000FF, 32'hDEADBEEF);
    step();
    e = expv(1'b1, 32'h000000FF, 5'd0, 2'b11, 1'b0, 1'b0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL imm_ff_ror0: got %h want %h", obs(), e);
    end
    drive(1'b1, 32'hE3A004FF, 32'h0);  // rotate field 4 -> ROR #8
    step();
    e = expv(1'b1, 32'h000000FF, 5'd8, 2'b11, 1'b0, 1'b0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL imm_ff_ror8: got %h want %h", obs(), e);
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL imm_drain: got out_valid %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [41:0] e;
    drive(1'b1, 32'hE1A00102, 32'd5);  // LSL #2
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready0: got %b want 1", bus.in_ready);
    end
    step();
    e = expv(1'b1, 32'd5, 5'd2, 2'b00, 1'b0, 1'b0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL b2b_lsl2: got %h want %h", obs(), e);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready1: got %b want 1", bus.in_ready);
    end
    drive(1'b1, 32'hE1A00142, 32'd4);  // ASR #2
    step();
    e = expv(1'b1, 32'd4, 5'd2, 2'b10, 1'b0, 1'b0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL b2b_asr2: got %h want %h", obs(), e);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready2: got %b want 1", bus.in_ready);
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_imm_special();
    logic [31:0] ins_t [4];
    logic [41:0] exp_t [4];
    ins_t[0] = 32'hE1A00022;  // LSR #0 -> #32
    exp_t[0] = expv(1'b1, 32'h1234, 5'd0, 2'b01, 1'b1, 1'b0);
    ins_t[1] = 32'hE1A00062;  // ROR #0 -> RRX
    exp_t[1] = expv(1'b1, 32'h1234, 5'd0, 2'b11, 1'b0, 1'b1);
    ins_t[2] = 32'hE1A00002;  // LSL #0 pass-through
    exp_t[2] = expv(1'b1, 32'h1234, 5'd0, 2'b00, 1'b0, 1'b0);
    ins_t[3] = 32'hE1A00042;  // ASR #0 -> #32
    exp_t[3] = expv(1'b1, 32'h1234, 5'd0, 2'b10, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ins_t[i], 32'h1234);
      step();
      drive(1'b0, 32'h0, 32'h0);
      vectors++;
      if (obs() !== exp_t[i]) begin
        miscompares++;
        $display("FAIL imm_special[%0d]: got %h want %h", i, obs(), exp_t[i]);
      end
      step();
    end
  endtask

  task automatic test_reg_shift();
    logic [3:0]  idx_t [7];
    logic [31:0] rsv_t [7];
    logic [31:0] ins_t [7];
    logic [31:0] rm_t  [7];
    logic [41:0] exp_t [7];
    idx_t[0] = 4'd3; rsv_t[0] = 32'h28;  ins_t[0] = 32'hE1A00352; rm_t[0] = 32'h80000000;
    exp_t[0] = expv(1'b1, 32'h80000000, 5'd0, 2'b10, 1'b1, 1'b0);
    idx_t[1] = 4'd3; rsv_t[1] = 32'h21;  ins_t[1] = 32'hE1A00372; rm_t[1] = 32'h80000000;
    exp_t[1] = expv(1'b1, 32'h80000000, 5'd1, 2'b11, 1'b0, 1'b0);
    idx_t[2] = 4'd5; rsv_t[2] = 32'd31;  ins_t[2] = 32'hE1A00532; rm_t[2] = 32'hF0;
    exp_t[2] = expv(1'b1, 32'hF0, 5'd31, 2'b01, 1'b0, 1'b0);
    idx_t[3] = 4'd5; rsv_t[3] = 32'd32;  ins_t[3] = 32'hE1A00532; rm_t[3] = 32'hF0;
    exp_t[3] = expv(1'b1, 32'hF0, 5'd0, 2'b01, 1'b1, 1'b0);
    idx_t[4] = 4'd5; rsv_t[4] = 32'h100; ins_t[4] = 32'hE1A00512; rm_t[4] = 32'hF0;
    exp_t[4] = expv(1'b1, 32'hF0, 5'd0, 2'b00, 1'b0, 1'b0);
    idx_t[5] = 4'd3; rsv_t[5] = 32'h28;  ins_t[5] = 32'hE1A00372; rm_t[5] = 32'h1;
    exp_t[5] = expv(1'b1, 32'h1, 5'd8, 2'b11, 1'b0, 1'b0);
    idx_t[6] = 4'd5; rsv_t[6] = 32'hFF;  ins_t[6] = 32'hE1A00512; rm_t[6] = 32'h7;
    exp_t[6] = expv(1'b1, 32'h7, 5'd0, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      rf[idx_t[i]] = rsv_t[i];
      drive(1'b1, ins_t[i], rm_t[i]);
      step();
      drive(1'b0, 32'h0, 32'h0);
      vectors++;
      if (bus.rs_addr !== idx_t[i] || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reg_rs_cycle[%0d]: got rs_addr=%0d in_ready=%b out_valid=%b want %0d 0 0",
                 i, bus.rs_addr, bus.in_ready, bus.out_valid, idx_t[i]);
      end
      step();
      vectors++;
      if (obs() !== exp_t[i]) begin
        miscompares++;
        $display("FAIL reg_result[%0d]: got %h want %h", i, obs(), exp_t[i]);
      end
      vectors++;
      if (bus.in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL reg_ready_after[%0d]: got %b want 1", i, bus.in_ready);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [41:0] e_first;
    logic [41:0] e_reg;
    e_first = expv(1'b1, 32'd5, 5'd2, 2'b00, 1'b0, 1'b0);
    e_reg   = expv(1'b1, 32'h80000000, 5'd0, 2'b10, 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hE1A00102, 32'd5);
    step();
    bus.out_ready = 1'b0;
    rf[3] = 32'h28;
    drive(1'b1, 32'hE1A00352, 32'h80000000);
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready);
      end
      step();
      vectors++;
      if (obs() !== e_first) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got %h want %h", i, obs(), e_first);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
    end
    step();
    drive(1'b0, 32'h0, 32'h0);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.rs_addr !== 4'd3 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_rs_state: got out_valid=%b rs_addr=%0d in_ready=%b want 0 3 0",
               bus.out_valid, bus.rs_addr, bus.in_ready);
    end
    step();
    vectors++;
    if (obs() !== e_reg) begin
      miscompares++;
      $display("FAIL bp_reg_result: got %h want %h", obs(), e_reg);
    end
    bus.out_ready = 1'b0;
    repeat (2) step();
    vectors++;
    if (obs() !== e_reg) begin
      miscompares++;
      $display("FAIL bp_reg_hold: got %h want %h", obs(), e_reg);
    end
    bus.out_ready = 1'b1;
    step();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_final_drain: got out_valid %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    rf[3] = 32'h21;
    drive(1'b1, 32'hE1A00372, 32'h55);
    step();
    drive(1'b0, 32'h0, 32'h0);
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.rs_addr !== 4'd3) begin
      miscompares++;
      $display("FAIL rstmid_in_rs: got in_ready=%b rs_addr=%0d want 0 3", bus.in_ready, bus.rs_addr);
    end
    reset = 1'b1;
    step();
    vectors++;
    if (obs() !== 42'd0 || bus.rs_addr !== 4'd0) begin
      miscompares++;
      $display("FAIL rstmid_cleared: got %h rs_addr=%0d want 0 0", obs(), bus.rs_addr);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_ready: got %b want 1", bus.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_discarded[%0d]: got out_valid %b want 0", i, bus.out_valid);
      end
    end
    // Reset takes priority over a simultaneous input transfer.
    reset = 1'b1;
    drive(1'b1, 32'hE3A000FF, 32'h0);
    step();
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_priority: got out_valid %b want 0", bus.out_valid);
    end
    step();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_priority_after: got out_valid %b want 0", bus.out_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.rm_data   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_immediate();
    test_back_to_back();
    test_imm_special();
    test_reg_shift();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
